// File: rtl/axi4_pkg.sv
// Shared AXI4 constants and FSM state types for the SRAM responder and its burst address generator.
package axi4_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } w_state_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } r_state_t;

    // Only these lengths give a power-of-two wrap boundary.
    function automatic logic wrap_len_ok(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

endpackage

// File: rtl/axi4_burst_addr_gen.sv
// Combinational AXI4 next-beat address for FIXED, INCR and WRAP bursts.
module axi4_burst_addr_gen
    import axi4_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [7:0]            len,
    input  logic [2:0]            size,
    input  logic [1:0]            burst,
    output logic [ADDR_WIDTH-1:0] next_addr
);

    logic [ADDR_WIDTH-1:0] nbytes;
    logic [ADDR_WIDTH-1:0] aligned;
    logic [ADDR_WIDTH-1:0] incr_addr;
    logic [ADDR_WIDTH-1:0] wrap_bytes;
    logic [ADDR_WIDTH-1:0] wrap_lower;

    always_comb begin
        nbytes     = ADDR_WIDTH'(1) << size;
        aligned    = addr & ~(nbytes - ADDR_WIDTH'(1));
        incr_addr  = aligned + nbytes;
        wrap_bytes = ADDR_WIDTH'({1'b0, len} + 9'd1) << size;
        wrap_lower = addr & ~(wrap_bytes - ADDR_WIDTH'(1));
        next_addr  = incr_addr;
        // Reserved burst type and WRAP with an unusable length both fall back to INCR.
        case (burst)
            BURST_FIXED: next_addr = addr;
            BURST_WRAP: begin
                if (wrap_len_ok(len) && (incr_addr == wrap_lower + wrap_bytes)) begin
                    next_addr = wrap_lower;
                end
            end
            default: next_addr = incr_addr;
        endcase
    end

endmodule

// File: rtl/axi4_sram_slave.sv
// AXI4 memory responder: independent write (AW/W/B) and read (AR/R) engines over a word-wide SRAM array.
module axi4_sram_slave
    import axi4_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int WID_WIDTH  = 6,
    parameter int RID_WIDTH  = 6,
    parameter int MEM_DEPTH  = 1024
) (
    input  logic                    ACLK,
    input  logic                    ARESETn,
    input  logic [WID_WIDTH-1:0]    AWID,
    input  logic [ADDR_WIDTH-1:0]   AWADDR,
    input  logic [7:0]              AWLEN,
    input  logic [2:0]              AWSIZE,
    input  logic [1:0]              AWBURST,
    input  logic [1:0]              AWLOCK,
    input  logic [3:0]              AWCACHE,
    input  logic [2:0]              AWPROT,
    input  logic                    AWVALID,
    output logic                    AWREADY,
    input  logic [DATA_WIDTH-1:0]   WDATA,
    input  logic [DATA_WIDTH/8-1:0] WSTRB,
    input  logic                    WLAST,
    input  logic                    WVALID,
    output logic                    WREADY,
    output logic [WID_WIDTH-1:0]    BID,
    output logic [1:0]              BRESP,
    output logic                    BVALID,
    input  logic                    BREADY,
    input  logic [RID_WIDTH-1:0]    ARID,
    input  logic [ADDR_WIDTH-1:0]   ARADDR,
    input  logic [7:0]              ARLEN,
    input  logic [2:0]              ARSIZE,
    input  logic [1:0]              ARBURST,
    input  logic [1:0]              ARLOCK,
    input  logic [3:0]              ARCACHE,
    input  logic [2:0]              ARPROT,
    input  logic                    ARVALID,
    output logic                    ARREADY,
    output logic [RID_WIDTH-1:0]    RID,
    output logic [DATA_WIDTH-1:0]   RDATA,
    output logic [DATA_WIDTH/8-1:0] RSTRB,
    output logic                    RLAST,
    output logic                    RVALID,
    input  logic                    RREADY
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int OFFS  = $clog2(BYTES);
    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic unused_inputs;
    assign unused_inputs = ^{AWLOCK, AWCACHE, AWPROT, ARLOCK, ARCACHE, ARPROT};

    // ---------------- write path ----------------
    w_state_t              w_state_reg, w_state_next;
    logic [WID_WIDTH-1:0]  w_id_reg;
    logic [ADDR_WIDTH-1:0] w_addr_reg, w_addr_next, w_word;
    logic [7:0]            w_len_reg, w_beat_reg;
    logic [2:0]            w_size_reg;
    logic [1:0]            w_burst_reg;
    logic                  w_err_reg;
    logic                  aw_fire, w_fire, b_fire, w_last_beat, w_beat_ok, mem_we;
    logic [IDX_W-1:0]      w_idx;

    assign aw_fire     = AWVALID && AWREADY;
    assign w_fire      = WVALID && WREADY;
    assign b_fire      = BVALID && BREADY;
    assign w_last_beat = (w_beat_reg == w_len_reg);
    assign w_word      = w_addr_reg >> OFFS;
    assign w_idx       = w_word[IDX_W-1:0];
    assign w_beat_ok   = (w_word < ADDR_WIDTH'(MEM_DEPTH)) && (w_size_reg <= 3'(OFFS));
    assign mem_we      = w_fire && w_beat_ok;

    axi4_burst_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_w_addr_gen (
        .addr      (w_addr_reg),
        .len       (w_len_reg),
        .size      (w_size_reg),
        .burst     (w_burst_reg),
        .next_addr (w_addr_next)
    );

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            w_state_reg <= W_IDLE;
        end else begin
            w_state_reg <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = w_state_reg;
        case (w_state_reg)
            W_IDLE:  if (aw_fire) w_state_next = W_DATA;
            W_DATA:  if (w_fire && w_last_beat) w_state_next = W_RESP;
            W_RESP:  if (b_fire) w_state_next = W_IDLE;
            default: w_state_next = W_IDLE;
        endcase
    end

    always_comb begin
        AWREADY = (w_state_reg == W_IDLE);
        WREADY  = (w_state_reg == W_DATA);
        BVALID  = (w_state_reg == W_RESP);
        BID     = w_id_reg;
        BRESP   = (BVALID && w_err_reg) ? RESP_SLVERR : RESP_OKAY;
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            w_id_reg    <= '0;
            w_addr_reg  <= '0;
            w_len_reg   <= '0;
            w_size_reg  <= '0;
            w_burst_reg <= '0;
            w_beat_reg  <= '0;
            w_err_reg   <= 1'b0;
        end else if (aw_fire) begin
            w_id_reg    <= AWID;
            w_addr_reg  <= AWADDR;
            w_len_reg   <= AWLEN;
            w_size_reg  <= AWSIZE;
            w_burst_reg <= AWBURST;
            w_beat_reg  <= '0;
            w_err_reg   <= 1'b0;
        end else if (w_fire) begin
            w_addr_reg <= w_addr_next;
            w_beat_reg <= w_beat_reg + 8'd1;
            // Error is sticky for the burst: bad beat address/size or WLAST not matching the count.
            if (!w_beat_ok || (WLAST != w_last_beat)) begin
                w_err_reg <= 1'b1;
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (mem_we) begin
            for (int b = 0; b < BYTES; b++) begin
                if (WSTRB[b]) begin
                    mem[w_idx][b*8 +: 8] <= WDATA[b*8 +: 8];
                end
            end
        end
    end

    // ---------------- read path ----------------
    r_state_t              r_state_reg, r_state_next;
    logic [RID_WIDTH-1:0]  r_id_reg;
    logic [ADDR_WIDTH-1:0] r_addr_reg, r_addr_next, r_word;
    logic [7:0]            r_len_reg, r_beat_reg;
    logic [2:0]            r_size_reg;
    logic [1:0]            r_burst_reg;
    logic                  ar_fire, r_fire, r_last_beat, r_beat_ok;
    logic [IDX_W-1:0]      r_idx;

    assign ar_fire     = ARVALID && ARREADY;
    assign r_fire      = RVALID && RREADY;
    assign r_last_beat = (r_beat_reg == r_len_reg);
    assign r_word      = r_addr_reg >> OFFS;
    assign r_idx       = r_word[IDX_W-1:0];
    assign r_beat_ok   = (r_word < ADDR_WIDTH'(MEM_DEPTH)) && (r_size_reg <= 3'(OFFS));

    axi4_burst_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_r_addr_gen (
        .addr      (r_addr_reg),
        .len       (r_len_reg),
        .size      (r_size_reg),
        .burst     (r_burst_reg),
        .next_addr (r_addr_next)
    );

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state_reg <= R_IDLE;
        end else begin
            r_state_reg <= r_state_next;
        end
    end

    always_comb begin
        r_state_next = r_state_reg;
        case (r_state_reg)
            R_IDLE:  if (ar_fire) r_state_next = R_DATA;
            R_DATA:  if (r_fire && r_last_beat) r_state_next = R_IDLE;
            default: r_state_next = R_IDLE;
        endcase
    end

    // Array read is combinational off the registered address, so a same-cycle write is not yet visible.
    always_comb begin
        ARREADY = (r_state_reg == R_IDLE);
        RVALID  = (r_state_reg == R_DATA);
        RLAST   = RVALID && r_last_beat;
        RID     = r_id_reg;
        RSTRB   = '1;
        RDATA   = '0;
        if (RVALID && r_beat_ok) begin
            RDATA = mem[r_idx];
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_id_reg    <= '0;
            r_addr_reg  <= '0;
            r_len_reg   <= '0;
            r_size_reg  <= '0;
            r_burst_reg <= '0;
            r_beat_reg  <= '0;
        end else if (ar_fire) begin
            r_id_reg    <= ARID;
            r_addr_reg  <= ARADDR;
            r_len_reg   <= ARLEN;
            r_size_reg  <= ARSIZE;
            r_burst_reg <= ARBURST;
            r_beat_reg  <= '0;
        end else if (r_fire) begin
            r_addr_reg <= r_addr_next;
            r_beat_reg <= r_beat_reg + 8'd1;
        end
    end

endmodule

// File: tb/tb_axi4_sram_slave.sv
// Directed self-checking bench for axi4_sram_slave on a 32-bit bus with 1024-word SRAM.
module tb_axi4_sram_slave;

    logic        ACLK = 1'b0;
    logic        ARESETn = 1'b0;
    logic [5:0]  AWID = '0, ARID = '0, BID, RID;
    logic [31:0] AWADDR = '0, ARADDR = '0, WDATA = '0, RDATA;
    logic [7:0]  AWLEN = '0, ARLEN = '0;
    logic [2:0]  AWSIZE = '0, ARSIZE = '0, AWPROT = '0, ARPROT = '0;
    logic [1:0]  AWBURST = '0, ARBURST = '0, AWLOCK = '0, ARLOCK = '0, BRESP;
    logic [3:0]  AWCACHE = '0, ARCACHE = '0, WSTRB = '0, RSTRB;
    logic        AWVALID = 0, AWREADY, WLAST = 0, WVALID = 0, WREADY, BVALID, BREADY = 0;
    logic        ARVALID = 0, ARREADY, RLAST, RVALID, RREADY = 0;

    int errors = 0;
    int checks = 0;

    logic [31:0] wbuf [16];
    logic [3:0]  sbuf [16];
    logic        lbuf [16];
    logic [31:0] rbuf [16];
    logic [31:0] hbuf [16];
    logic        rlbuf [16];
    logic [5:0]  rid_seen;
    logic [1:0]  resp;
    logic [5:0]  bid_seen;

    always #5 ACLK = ~ACLK;

    axi4_sram_slave #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .WID_WIDTH(6), .RID_WIDTH(6), .MEM_DEPTH(1024)
    ) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWLOCK(AWLOCK), .AWCACHE(AWCACHE), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARLOCK(ARLOCK), .ARCACHE(ARCACHE), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RSTRB(RSTRB), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    // Caller fills wbuf/sbuf/lbuf; entered and left at 1 ns after a rising edge.
    task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                            input logic [1:0] burst, input logic [5:0] id,
                            output logic [1:0] bresp_o, output logic [5:0] bid_o);
        int n;
        AWADDR = addr; AWLEN = len; AWSIZE = size; AWBURST = burst; AWID = id; AWVALID = 1;
        n = 0;
        while (!AWREADY && n < 100) begin tick(); n++; end
        if (!AWREADY) check_eq("aw_timeout", 0, 1);
        tick();
        AWVALID = 0;
        for (int b = 0; b <= int'(len); b++) begin
            WDATA = wbuf[b]; WSTRB = sbuf[b]; WLAST = lbuf[b]; WVALID = 1;
            n = 0;
            while (!WREADY && n < 100) begin tick(); n++; end
            if (!WREADY) check_eq("w_timeout", 0, 1);
            tick();
        end
        WVALID = 0; WLAST = 0;
        BREADY = 1;
        n = 0;
        while (!BVALID && n < 100) begin tick(); n++; end
        if (!BVALID) check_eq("b_timeout", 0, 1);
        bresp_o = BRESP;
        bid_o = BID;
        tick();
        BREADY = 0;
        $display("write addr=%08h len=%0d size=%0d burst=%0d id=%0h -> bresp=%0d bid=%0h",
                 addr, len, size, burst, id, bresp_o, bid_o);
    endtask

    // Fills hbuf (data first seen), rbuf (data at handshake), rlbuf, rid_seen. With stall, each beat waits a cycle.
    task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input logic [5:0] id, input logic stall);
        int n;
        ARADDR = addr; ARLEN = len; ARSIZE = size; ARBURST = burst; ARID = id; ARVALID = 1;
        n = 0;
        while (!ARREADY && n < 100) begin tick(); n++; end
        if (!ARREADY) check_eq("ar_timeout", 0, 1);
        tick();
        ARVALID = 0;
        RREADY = !stall;
        for (int b = 0; b <= int'(len); b++) begin
            n = 0;
            while (!RVALID && n < 100) begin tick(); n++; end
            if (!RVALID) check_eq("r_timeout", 0, 1);
            if (!stall) check_eq("r_back_to_back", n, 0);
            hbuf[b] = RDATA;
            if (stall) begin
                tick();
                check_eq("r_hold_valid", RVALID, 1);
            end
            rbuf[b] = RDATA;
            rlbuf[b] = RLAST;
            rid_seen = RID;
            RREADY = 1;
            tick();
            RREADY = !stall;
        end
        RREADY = 0;
        check_eq("r_done_valid", RVALID, 0);
        $display("read addr=%08h len=%0d size=%0d burst=%0d id=%0h -> beat0=%08h last_beat=%08h rid=%0h",
                 addr, len, size, burst, id, rbuf[0], rbuf[len], rid_seen);
    endtask

    task automatic fill_single(input logic [31:0] d, input logic [3:0] s);
        wbuf[0] = d; sbuf[0] = s; lbuf[0] = 1;
    endtask

    logic [31:0] exp4 [4];

    initial begin
        // reset values
        repeat (3) @(posedge ACLK);
        #1;
        check_eq("rst_awready", AWREADY, 1);
        check_eq("rst_arready", ARREADY, 1);
        check_eq("rst_wready", WREADY, 0);
        check_eq("rst_bvalid", BVALID, 0);
        check_eq("rst_rvalid", RVALID, 0);
        check_eq("rst_rlast", RLAST, 0);
        check_eq("rst_bid_rid_bresp", {BID, RID, BRESP}, 0);
        check_eq("rst_rdata", RDATA, 0);
        ARESETn = 1;
        tick();

        // INCR write 1..4 at 0x10, read back
        for (int i = 0; i < 4; i++) begin
            wbuf[i] = 32'(i + 1); sbuf[i] = 4'hF; lbuf[i] = (i == 3);
        end
        do_write(32'h10, 8'd3, 3'd2, 2'b01, 6'h2A, resp, bid_seen);
        check_eq("incr_bresp", resp, 2'b00);
        check_eq("incr_bid", bid_seen, 6'h2A);
        do_read(32'h10, 8'd3, 3'd2, 2'b01, 6'h15, 1'b0);
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("incr_rdata%0d", i), rbuf[i], 32'(i + 1));
            check_eq($sformatf("incr_rlast%0d", i), rlbuf[i], (i == 3));
        end
        check_eq("incr_rid", rid_seen, 6'h15);

        // WRAP read from 0x38 over words 0x30..0x3C
        for (int i = 0; i < 4; i++) begin
            wbuf[i] = 32'hA0 + 32'(i); sbuf[i] = 4'hF; lbuf[i] = (i == 3);
        end
        do_write(32'h30, 8'd3, 3'd2, 2'b01, 6'h01, resp, bid_seen);
        do_read(32'h38, 8'd3, 3'd2, 2'b10, 6'h02, 1'b0);
        exp4[0] = 32'hA2; exp4[1] = 32'hA3; exp4[2] = 32'hA0; exp4[3] = 32'hA1;
        for (int i = 0; i < 4; i++) check_eq($sformatf("wrap_rdata%0d", i), rbuf[i], exp4[i]);

        // byte strobes and read backpressure
        fill_single(32'h0000_0000, 4'hF);
        do_write(32'h100, 8'd0, 3'd2, 2'b01, 6'h03, resp, bid_seen);
        fill_single(32'hFFFF_FFFF, 4'b0101);
        do_write(32'h100, 8'd0, 3'd2, 2'b01, 6'h03, resp, bid_seen);
        fill_single(32'hCAFE_BABE, 4'hF);
        do_write(32'h104, 8'd0, 3'd2, 2'b01, 6'h03, resp, bid_seen);
        do_read(32'h100, 8'd1, 3'd2, 2'b01, 6'h04, 1'b1);
        check_eq("strb_first", hbuf[0], 32'h00FF_00FF);
        check_eq("strb_held", rbuf[0], 32'h00FF_00FF);
        check_eq("stall_beat1", rbuf[1], 32'hCAFE_BABE);
        check_eq("stall_rlast1", rlbuf[1], 1);

        // FIXED write: last beat wins
        for (int i = 0; i < 3; i++) begin
            wbuf[i] = 32'h100 + 32'(i); sbuf[i] = 4'hF; lbuf[i] = (i == 2);
        end
        do_write(32'h300, 8'd2, 3'd2, 2'b00, 6'h05, resp, bid_seen);
        check_eq("fixed_bresp", resp, 2'b00);
        do_read(32'h300, 8'd1, 3'd2, 2'b00, 6'h05, 1'b0);
        check_eq("fixed_rdata0", rbuf[0], 32'h102);
        check_eq("fixed_rdata1", rbuf[1], 32'h102);

        // errors: out of range, early WLAST, illegal size
        fill_single(32'h1111_1111, 4'hF);
        do_write(32'h0, 8'd0, 3'd2, 2'b01, 6'h06, resp, bid_seen);
        fill_single(32'hDEAD_BEEF, 4'hF);
        do_write(32'h1000, 8'd0, 3'd2, 2'b01, 6'h07, resp, bid_seen);
        check_eq("oor_bresp", resp, 2'b10);
        check_eq("oor_bid", bid_seen, 6'h07);
        do_read(32'h0, 8'd0, 3'd2, 2'b01, 6'h08, 1'b0);
        check_eq("oor_mem_unchanged", rbuf[0], 32'h1111_1111);
        do_read(32'h1000, 8'd0, 3'd2, 2'b01, 6'h08, 1'b0);
        check_eq("oor_rdata_zero", rbuf[0], 32'h0);
        for (int i = 0; i < 4; i++) begin
            wbuf[i] = 32'h50 + 32'(i); sbuf[i] = 4'hF; lbuf[i] = (i == 1);
        end
        do_write(32'h200, 8'd3, 3'd2, 2'b01, 6'h09, resp, bid_seen);
        check_eq("wlast_early_bresp", resp, 2'b10);
        fill_single(32'h7777_7777, 4'hF);
        do_write(32'h0, 8'd0, 3'd3, 2'b01, 6'h0A, resp, bid_seen);
        check_eq("badsize_bresp", resp, 2'b10);
        do_read(32'h0, 8'd0, 3'd2, 2'b01, 6'h0B, 1'b0);
        check_eq("badsize_no_write", rbuf[0], 32'h1111_1111);
        fill_single(32'h2222_2222, 4'hF);
        do_write(32'h0, 8'd0, 3'd2, 2'b01, 6'h0C, resp, bid_seen);
        check_eq("ok_after_err_bresp", resp, 2'b00);

        // concurrent read and write of word 5
        fill_single(32'h5A5A_5A5A, 4'hF);
        do_write(32'h14, 8'd0, 3'd2, 2'b01, 6'h0D, resp, bid_seen);
        AWADDR = 32'h14; AWLEN = 0; AWSIZE = 2; AWBURST = 2'b01; AWID = 6'h0E; AWVALID = 1;
        ARADDR = 32'h14; ARLEN = 0; ARSIZE = 2; ARBURST = 2'b01; ARID = 6'h0F; ARVALID = 1;
        tick();
        AWVALID = 0; ARVALID = 0;
        WDATA = 32'h0000_00A5; WSTRB = 4'hF; WLAST = 1; WVALID = 1; RREADY = 1;
        check_eq("conc_wready", WREADY, 1);
        check_eq("conc_rvalid", RVALID, 1);
        check_eq("conc_rdata_old", RDATA, 32'h5A5A_5A5A);
        tick();
        WVALID = 0; WLAST = 0; RREADY = 0;
        check_eq("conc_bvalid", BVALID, 1);
        check_eq("conc_bid", BID, 6'h0E);
        BREADY = 1;
        tick();
        BREADY = 0;
        $display("concurrent write/read word 5 done");
        do_read(32'h14, 8'd0, 3'd2, 2'b01, 6'h10, 1'b0);
        check_eq("conc_rdata_new", rbuf[0], 32'h0000_00A5);

        // async reset in the middle of a read burst
        ARADDR = 32'h10; ARLEN = 3; ARSIZE = 2; ARBURST = 2'b01; ARID = 6'h11; ARVALID = 1;
        tick();
        ARVALID = 0;
        check_eq("midrst_rvalid_before", RVALID, 1);
        #2;
        ARESETn = 0;
        #1;
        check_eq("midrst_rvalid", RVALID, 0);
        check_eq("midrst_rdata", RDATA, 0);
        tick();
        ARESETn = 1;
        tick();
        check_eq("post_rst_awready", AWREADY, 1);
        check_eq("post_rst_arready", ARREADY, 1);
        check_eq("post_rst_rvalid", RVALID, 0);
        check_eq("post_rst_bvalid", BVALID, 0);
        $display("reset during read burst done");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1, "timeout");
    end

endmodule
